// File: rtl/lcd_msg_arbiter.sv
// rtl/lcd_msg_arbiter.sv - HD44780 8-bit bus owner: power-up init, then round-robin 16-char line writes for two producers
module lcd_msg_arbiter #(
    parameter int EN_CYCLES = 4,
    parameter int CMD_WAIT  = 8,
    parameter int CLR_WAIT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   line_sel,
    input  logic [127:0] msg0,
    input  logic [127:0] msg1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         init_done,
    output logic         busy,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en
);
    localparam int CNT_MAX = (EN_CYCLES > CLR_WAIT) ? EN_CYCLES : CLR_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] EN_LOAD  = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {M_INIT, M_IDLE, M_ADDR, M_CHARS, M_DONE} main_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_t;

    main_t         main_q, main_d;
    wr_t           wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [3:0]    char_idx_q, char_idx_d;
    logic [127:0]  buf_q, buf_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          init_done_q, init_done_d;
    logic          slot_end;
    logic          winner;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= M_INIT;
            wr_q        <= W_IDLE;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            char_idx_q  <= '0;
            buf_q       <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            owner_q     <= 1'b0;
            // "last served = 1" so requester 0 wins the first tie
            last_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            main_q      <= main_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            char_idx_q  <= char_idx_d;
            buf_q       <= buf_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        main_d      = main_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        char_idx_d  = char_idx_q;
        buf_d       = buf_q;
        data_d      = data_q;
        rs_d        = rs_q;
        owner_d     = owner_q;
        last_d      = last_q;
        init_done_d = init_done_q;

        slot_end = (wr_q == W_HOLD) && (cnt_q == '0);
        winner   = (req == 2'b11) ? ~last_q : req[1];

        case (wr_q)
            W_SETUP: begin
                wr_d  = W_PULSE;
                cnt_d = EN_LOAD;
            end
            W_PULSE: begin
                if (cnt_q == '0) begin
                    wr_d  = W_HOLD;
                    cnt_d = (!rs_q && data_q == 8'h01) ? CLR_LOAD : CMD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            W_HOLD: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
            end
            default: ;
        endcase

        case (main_q)
            M_INIT: begin
                if (wr_q == W_IDLE) begin
                    wr_d   = W_SETUP;
                    data_d = init_cmd(init_idx_q);
                    rs_d   = 1'b0;
                end else if (slot_end) begin
                    if (init_idx_q == 2'd3) begin
                        main_d      = M_IDLE;
                        wr_d        = W_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        data_d     = init_cmd(init_idx_q + 2'd1);
                        wr_d       = W_SETUP;
                    end
                end
            end
            M_IDLE: begin
                if (|req) begin
                    main_d  = M_ADDR;
                    owner_d = winner;
                    buf_d   = winner ? msg1 : msg0;
                    data_d  = line_sel[winner] ? 8'hC0 : 8'h80;
                    rs_d    = 1'b0;
                    wr_d    = W_SETUP;
                end
            end
            M_ADDR: begin
                if (slot_end) begin
                    main_d     = M_CHARS;
                    char_idx_d = '0;
                    data_d     = buf_q[127:120];
                    buf_d      = {buf_q[119:0], 8'h00};
                    rs_d       = 1'b1;
                    wr_d       = W_SETUP;
                end
            end
            M_CHARS: begin
                if (slot_end) begin
                    if (char_idx_q == 4'd15) begin
                        main_d = M_DONE;
                        wr_d   = W_IDLE;
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                        data_d     = buf_q[127:120];
                        buf_d      = {buf_q[119:0], 8'h00};
                        wr_d       = W_SETUP;
                    end
                end
            end
            M_DONE: begin
                main_d = M_IDLE;
                last_d = owner_q;
            end
            default: main_d = M_INIT;
        endcase
    end

    assign gnt       = (main_q == M_ADDR || main_q == M_CHARS) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign done      = (main_q == M_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (main_q != M_IDLE);
    assign init_done = init_done_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = (wr_q == W_PULSE);

endmodule
